// File: rtl/cpu_trace_buffer_pkg.sv
// Shared definitions for the CPU trace capture path.
// Covers the record layout, frame constants and sender states.
package cpu_trace_buffer_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 14;
    localparam int         REC_W       = 104;
    localparam int         FRAME_W     = FRAME_BYTES * 8;
    localparam int         SEQ_W       = 7;

    // Field order fixes the bit offsets: seq[103:97], zero[96], pc[95:64], inst[63:32], alu[31:0].
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        logic             zero;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [31:0]      alu;
    } trace_rec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/cpu_trace_buffer_fifo.sv
// Single-clock record FIFO with registered occupancy.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module cpu_trace_buffer_fifo #(
    parameter int WIDTH = 104,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == FULL_LEVEL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW + 1)'(1);
                2'b01:   level_q <= level_q - (AW + 1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // NOTE: storage is not reset; entries are only read after being written, and pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Captures committed-instruction trace records into a FIFO and streams
// each one out as a 14-byte frame over a valid/ready byte interface.
module cpu_trace_buffer
    import cpu_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_en,
    input  logic                   commit,
    input  logic [31:0]            OLD_PC,
    input  logic [31:0]            inst,
    input  logic [31:0]            ALU_Result,
    input  logic                   ALU_Zero,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [SEQ_W-1:0]   seq_q;
    logic               overflow_q;
    logic [DROP_W-1:0]  drop_q;

    trace_rec_t         rec_in;
    logic [REC_W-1:0]   fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               capture;
    logic               push;
    logic               pop;
    logic               drop;

    assign rec_in  = '{seq: seq_q, zero: ALU_Zero, pc: OLD_PC, inst: inst, alu: ALU_Result};
    assign pop     = (state_q == ST_IDLE) && !fifo_empty;
    assign capture = commit && trace_en;
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && !push;

    cpu_trace_buffer_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    frame_d = {SYNC_BYTE, fifo_dout};
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // The frame shifts out MSB byte first; it is all zeros once the last byte leaves.
                if (out_ready) begin
                    frame_d = {frame_q[FRAME_W-9:0], 8'h00};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == LAST_IDX) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            frame_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            if (push) seq_q <= seq_q + SEQ_W'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
            end
        end
    end

    assign out_valid  = (state_q == ST_SEND);
    assign out_data   = frame_q[FRAME_W-1 -: 8];
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed frame vectors, corner
// sequences and randomized traffic compared every cycle with a queue model.
module tb_cpu_trace_buffer;

    localparam int DEPTH    = 16;
    localparam int DROP_W   = 8;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   trace_en;
    logic                   commit;
    logic [31:0]            OLD_PC;
    logic [31:0]            inst;
    logic [31:0]            ALU_Result;
    logic                   ALU_Zero;
    logic [7:0]             out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   overflow;
    logic [DROP_W-1:0]      drop_count;
    logic [$clog2(DEPTH):0] fifo_level;

    cpu_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .trace_en   (trace_en),
        .commit     (commit),
        .OLD_PC     (OLD_PC),
        .inst       (inst),
        .ALU_Result (ALU_Result),
        .ALU_Zero   (ALU_Zero),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .drop_count (drop_count),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  pc;
        logic [31:0]  ins;
        logic [31:0]  alu;
        logic         zero;
        logic [111:0] exp;
    } vec_t;

    vec_t         vecs [4];
    int           total = 0;
    int           bad   = 0;
    logic [7:0]   got [$];

    // Reference model: record queue, the frame being sent and bytes still to send.
    logic [103:0] m_q [$];
    logic [111:0] m_frame;
    int           m_rem;
    int           m_seq;
    int           m_drops;
    bit           m_ovf;

    logic [7:0]   hold_d;
    logic         hold_v;
    bit           rdy;
    int           k;
    int           n0;
    logic [111:0] f;
    logic [31:0]  w;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_update(input bit c, input bit en, input logic [31:0] pc,
                                         input logic [31:0] ins, input logic [31:0] alu,
                                         input bit z, input bit rdy_i, input bit rn);
        bit pop;
        bit push;
        if (!rn) begin
            m_q.delete();
            m_rem   = 0;
            m_seq   = 0;
            m_drops = 0;
            m_ovf   = 1'b0;
            return;
        end
        pop = (m_rem == 0) && (m_q.size() > 0);
        if (m_rem > 0 && rdy_i) m_rem--;
        push = c && en && (m_q.size() < DEPTH || pop);
        if (pop) begin
            m_frame = {8'hA5, m_q.pop_front()};
            m_rem   = 14;
        end
        if (push) begin
            m_q.push_back({7'(m_seq), z, pc, ins, alu});
            m_seq = (m_seq + 1) % 128;
        end else if (c && en) begin
            m_ovf = 1'b1;
            if (m_drops < DROP_MAX) m_drops++;
        end
    endfunction

    // Drive one cycle of inputs, compare outputs with the model, then advance one edge.
    task automatic step(input bit c, input bit en, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] alu, input bit z, input bit rdy_i, input bit rn);
        commit     = c;
        trace_en   = en;
        OLD_PC     = pc;
        inst       = ins;
        ALU_Result = alu;
        ALU_Zero   = z;
        out_ready  = rdy_i;
        rst        = rn;
        check("out_valid", 128'(out_valid), 128'(m_rem > 0));
        if (m_rem > 0)
            check("out_data", 128'(out_data), 128'(m_frame[111 - 8 * (14 - m_rem) -: 8]));
        check("fifo_level", 128'(fifo_level), 128'(m_q.size()));
        check("overflow", 128'(overflow), 128'(m_ovf));
        check("drop_count", 128'(drop_count), 128'(m_drops));
        if (rn && out_valid && rdy_i) got.push_back(out_data);
        @(posedge clk);
        model_update(c, en, pc, ins, alu, z, rdy_i, rn);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy_i);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, '0, '0, 1'b0, rdy_i, 1'b1);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int cnt = 0;
        while (got.size() < n && cnt < budget) begin
            step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b1);
            cnt++;
        end
        check(name, 128'(got.size()), 128'(n));
    endtask

    function automatic logic [111:0] frame_at(input int idx);
        logic [111:0] r = '0;
        for (int j = 0; j < 14; j++) r = {r[103:0], got[14 * idx + j]};
        return r;
    endfunction

    initial begin
        vecs[0] = '{32'h0000_0004, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0,
                    112'hA5_00_00000004_12345678_DEADBEEF};
        vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1,
                    112'hA5_03_80000000_FFFFFFFF_00000000};
        vecs[2] = '{32'h0000_1000, 32'h0000_0013, 32'h0000_0001, 1'b0,
                    112'hA5_04_00001000_00000013_00000001};
        vecs[3] = '{32'hCAFE_BABE, 32'h0BAD_F00D, 32'h7FFF_FFFF, 1'b1,
                    112'hA5_07_CAFEBABE_0BADF00D_7FFFFFFF};

        rst = 1'b0; commit = 1'b0; trace_en = 1'b0; out_ready = 1'b0;
        OLD_PC = '0; inst = '0; ALU_Result = '0; ALU_Zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_update(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_overflow", 128'(overflow), 128'(0));
        check("rst_drop_count", 128'(drop_count), 128'(0));
        check("rst_fifo_level", 128'(fifo_level), 128'(0));

        // Single records: two-cycle latency, exact byte order, valid drops after byte 13.
        for (int i = 0; i < 4; i++) begin
            got.delete();
            step(1'b1, 1'b1, vecs[i].pc, vecs[i].ins, vecs[i].alu, vecs[i].zero, 1'b1, 1'b1);
            check("t1_gap_valid", 128'(out_valid), 128'(0));
            idle(1, 1'b1);
            check("t1_first_valid", 128'(out_valid), 128'(1));
            check("t1_first_byte", 128'(out_data), 128'(8'hA5));
            wait_bytes(14, 40, "t1_byte_count");
            f = frame_at(0);
            check("t1_frame", 128'(f), 128'(vecs[i].exp));
            check("t1_valid_drops", 128'(out_valid), 128'(0));
        end

        // Backpressure: ready toggles every cycle; stalled bytes must hold.
        got.delete();
        step(1'b1, 1'b1, 32'h4, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        rdy = 1'b0;
        k = 0;
        while (got.size() < 14 && k < 100) begin
            hold_v = out_valid;
            hold_d = out_data;
            step(1'b0, 1'b1, '0, '0, '0, 1'b0, rdy, 1'b1);
            if (hold_v && !rdy) begin
                check("t2_hold_valid", 128'(out_valid), 128'(1));
                check("t2_hold_data", 128'(out_data), 128'(hold_d));
            end
            rdy = !rdy;
            k++;
        end
        check("t2_byte_count", 128'(got.size()), 128'(14));
        f = frame_at(0);
        check("t2_frame", 128'(f), 128'(112'hA5_08_00000004_12345678_DEADBEEF));
        idle(3, 1'b1);

        // Overflow: one record sits in the frame register, 16 fill the FIFO, 4 are dropped.
        step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        got.delete();
        for (int i = 0; i < 21; i++) step(1'b1, 1'b1, 32'(i), 32'h13, 32'(i), 1'b0, 1'b0, 1'b1);
        check("t3_level", 128'(fifo_level), 128'(16));
        check("t3_overflow", 128'(overflow), 128'(1));
        check("t3_drops", 128'(drop_count), 128'(4));

        // Full FIFO with a commit on the very cycle the idle sender pops.
        k = 0;
        while (out_valid && k < 100) begin
            step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b1);
            k++;
        end
        check("t4_idle_reached", 128'(out_valid), 128'(0));
        step(1'b1, 1'b1, 32'h77, 32'h13, 32'h77, 1'b1, 1'b1, 1'b1);
        check("t4_level", 128'(fifo_level), 128'(16));
        check("t4_drops", 128'(drop_count), 128'(4));
        wait_bytes(18 * 14, 18 * 15 + 20, "t4_drain");
        for (int i = 0; i < 18; i++) check("t4_seq", 128'(got[14 * i + 1][7:1]), 128'(i));
        w = {got[14 * 17 + 2], got[14 * 17 + 3], got[14 * 17 + 4], got[14 * 17 + 5]};
        check("t4_last_pc", 128'(w), 128'(32'h77));
        check("t4_last_zero", 128'(got[14 * 17 + 1][0]), 128'(1));

        // Sequence wrap after 128 records, then commits with capture disabled.
        step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        got.delete();
        for (int i = 0; i < 130; i++) begin
            step(1'b1, 1'b1, 32'(i), 32'(i), 32'(i), 1'(i), 1'b1, 1'b1);
            idle(14, 1'b1);
        end
        wait_bytes(130 * 14, 60, "t5_frames");
        check("t5_seq127", 128'(got[14 * 127 + 1][7:1]), 128'(127));
        check("t5_seq_wrap", 128'(got[14 * 128 + 1][7:1]), 128'(0));
        check("t5_seq_after", 128'(got[14 * 129 + 1][7:1]), 128'(1));
        n0 = got.size();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'(i), '0, '0, 1'b0, 1'b1, 1'b1);
        idle(30, 1'b1);
        check("t5_no_frames", 128'(got.size()), 128'(n0));
        check("t5_no_drops", 128'(drop_count), 128'(0));

        // Reset mid-frame after byte 5 with records still queued.
        step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        got.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h100 + 32'(i), 32'h13, 32'(i), 1'b0, 1'b0, 1'b1);
        wait_bytes(6, 40, "t6_six_bytes");
        step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("t6_valid_low", 128'(out_valid), 128'(0));
        check("t6_level_zero", 128'(fifo_level), 128'(0));
        got.delete();
        step(1'b1, 1'b1, 32'hABC, 32'h13, 32'h5, 1'b1, 1'b1, 1'b1);
        wait_bytes(14, 40, "t6_fresh_frame");
        check("t6_sync", 128'(got[0]), 128'(8'hA5));
        check("t6_seq_zero", 128'(got[1]), 128'(8'h01));

        // Drop counter saturation.
        step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 32'(i), '0, '0, 1'b0, 1'b0, 1'b1);
        check("sat_drops", 128'(drop_count), 128'(DROP_MAX));
        check("sat_overflow", 128'(overflow), 128'(1));

        // Randomized traffic against the model.
        step(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2500; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8, $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6, 1'b1);
        end
        idle(300, 1'b1);
        check("rand_drained", 128'(out_valid), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
